vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator with a pixel-fetch interface. Successor to the fixed-mode counter: fully generic porch/sync/active timing, selectable sync polarity, pixel-clock divider and configurable frame-buffer fetch latency.
- Horizontal and vertical counters run in a single clock domain; there is no derived-edge clocking.
- Sits between the frame buffer (which answers fetches) and the VGA pins (syncs, R/G/B).

---
 rtl/vga_pkg.sv | 33 +++
 rtl/delay_line.sv | 29 ++
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared defaults and types for the VGA timing generator: default mode timing,
// colour depths and the bundle of per-pixel flags carried down the output pipeline.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 200;
    localparam int DEF_H_FP     = 10;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 22;

    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    localparam int DEF_R_DEPTH  = 2;
    localparam int DEF_G_DEPTH  = 2;
    localparam int DEF_B_DEPTH  = 2;
    localparam int DEF_PIX_W    = DEF_R_DEPTH + DEF_G_DEPTH + DEF_B_DEPTH;

    // Flags decoded from the counters that must stay aligned with the colour data.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic line_start;
        logic frame_start;
    } timing_bundle_t;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Reset-clearable shift register of DEPTH stages; dout is din delayed DEPTH clocks.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Generic VGA timing generator: pixel counters, frame-buffer fetch requests and a
// FETCH_LAT+1 deep output pipeline that keeps syncs/enables aligned with the colour.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int PIX_DIV   = 1,
    parameter int FETCH_LAT = 1,
    parameter int R_DEPTH   = DEF_R_DEPTH,
    parameter int G_DEPTH   = DEF_G_DEPTH,
    parameter int B_DEPTH   = DEF_B_DEPTH,
    localparam int H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int H_BITS   = $clog2(H_TOTAL),
    localparam int V_BITS   = $clog2(V_TOTAL),
    localparam int PIX_W    = R_DEPTH + G_DEPTH + B_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               fetch_valid,
    output logic [H_BITS-1:0]  fetch_x,
    output logic [V_BITS-1:0]  fetch_y,
    output logic               h_sync_pulse,
    output logic               v_sync_pulse,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [R_DEPTH-1:0] R,
    output logic [G_DEPTH-1:0] G,
    output logic [B_DEPTH-1:0] B
);

    if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
        PIX_DIV < 1 || FETCH_LAT < 1) begin : g_bad_params
        $error("vga_timing_gen: zero timing parameter, PIX_DIV<1 or FETCH_LAT<1");
    end

    localparam int DIV_BITS = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(PIX_DIV - 1);
    localparam logic [H_BITS-1:0]   H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0]   V_LAST   = V_BITS'(V_TOTAL - 1);

    // Region bounds carry one spare bit so a zero back porch cannot overflow them.
    localparam logic [H_BITS:0] H_ACT_END  = (H_BITS+1)'(H_ACTIVE);
    localparam logic [H_BITS:0] HS_START   = (H_BITS+1)'(H_ACTIVE + H_FP);
    localparam logic [H_BITS:0] HS_END     = (H_BITS+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_BITS:0] V_ACT_END  = (V_BITS+1)'(V_ACTIVE);
    localparam logic [V_BITS:0] VS_START   = (V_BITS+1)'(V_ACTIVE + V_FP);
    localparam logic [V_BITS:0] VS_END     = (V_BITS+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_BITS-1:0] div_cnt;
    logic [H_BITS-1:0]   h_count;
    logic [V_BITS-1:0]   v_count;
    logic [H_BITS:0]     h_ext;
    logic [V_BITS:0]     v_ext;
    logic                tick;
    logic                first;
    logic                cap;
    timing_bundle_t      cur_bundle;
    timing_bundle_t      out_bundle;

    assign tick  = (div_cnt == DIV_LAST);
    assign first = (div_cnt == '0);
    assign h_ext = {1'b0, h_count};
    assign v_ext = {1'b0, v_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_count <= '0;
            v_count <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_bundle.active      = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        cur_bundle.hs          = (h_ext >= HS_START) && (h_ext < HS_END);
        cur_bundle.vs          = (v_ext >= VS_START) && (v_ext < VS_END);
        cur_bundle.line_start  = first && (h_count == '0);
        cur_bundle.frame_start = first && (h_count == '0) && (v_count == '0);
    end

    // Requests are suppressed while in reset even though the counters read (0,0).
    assign fetch_valid = ~rst & first & cur_bundle.active;
    assign fetch_x     = h_count;
    assign fetch_y     = v_count;

    delay_line #(.WIDTH(1), .DEPTH(FETCH_LAT)) cap_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (fetch_valid),
        .dout (cap)
    );

    delay_line #(.WIDTH($bits(timing_bundle_t)), .DEPTH(FETCH_LAT)) flag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (cur_bundle),
        .dout (out_bundle)
    );

    // Final register stage: the extra +1 of latency, and the only path to the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            de           <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            h_sync_pulse <= ~H_POL;
            v_sync_pulse <= ~V_POL;
            R            <= '0;
            G            <= '0;
            B            <= '0;
        end else begin
            de           <= out_bundle.active;
            line_start   <= out_bundle.line_start;
            frame_start  <= out_bundle.frame_start;
            h_sync_pulse <= out_bundle.hs ? H_POL : ~H_POL;
            v_sync_pulse <= out_bundle.vs ? V_POL : ~V_POL;
            if (!out_bundle.active) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else if (cap) begin
                R <= pix_data[PIX_W-1 -: R_DEPTH];
                G <= pix_data[B_DEPTH +: G_DEPTH];
                B <= pix_data[B_DEPTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator configurations run side by side against a
// behavioural model; a model frame buffer answers fetches with fetch_x[5:0].
module tb_vga_timing_gen;

    // Config 0: default horizontal timing, short frame. 1: PIX_DIV=2, FETCH_LAT=3,
    // H_POL=1. 2: minimal H 4/1/1/1, V 2/1/1/1.
    localparam int P_HA   [3] = '{200, 200, 4};
    localparam int P_HF   [3] = '{10, 10, 1};
    localparam int P_HS   [3] = '{32, 32, 1};
    localparam int P_HB   [3] = '{22, 22, 1};
    localparam int P_VA   [3] = '{10, 4, 2};
    localparam int P_VF   [3] = '{1, 1, 1};
    localparam int P_VS   [3] = '{4, 1, 1};
    localparam int P_VB   [3] = '{23, 1, 1};
    localparam bit P_HPOL [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit P_VPOL [3] = '{1'b0, 1'b0, 1'b1};
    localparam int P_DIV  [3] = '{1, 2, 1};
    localparam int P_LAT  [3] = '{1, 3, 1};

    typedef struct {
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int rgb;
    } exp_t;

    logic clk;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic [5:0] pix_a = '0;
    logic [5:0] pix_b = '0;
    logic [5:0] pix_c = '0;

    logic       fv_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [8:0] fx_a;
    logic [5:0] fy_a;
    logic [1:0] r_a, g_a, b_a;
    logic       fv_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [8:0] fx_b;
    logic [2:0] fy_b;
    logic [1:0] r_b, g_b, b_b;
    logic       fv_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [2:0] fx_c;
    logic [2:0] fy_c;
    logic [1:0] r_c, g_c, b_c;

    int checks = 0;
    int errors = 0;

    exp_t scb_q [3][$];
    int   mh [3], mv [3], mdiv [3];
    bit   armed [3];
    int   cyc [3], last_ls [3], last_fs [3], hs_run [3], vs_run [3];
    bit   have_ls [3], have_fs [3];
    bit   fb_v [3][8];
    int   fb_d [3][8];
    int   p_a, p_b, p_c;
    bit   found;

    vga_timing_gen #(
        .H_ACTIVE(P_HA[0]), .H_FP(P_HF[0]), .H_SYNC(P_HS[0]), .H_BP(P_HB[0]),
        .V_ACTIVE(P_VA[0]), .V_FP(P_VF[0]), .V_SYNC(P_VS[0]), .V_BP(P_VB[0]),
        .H_POL(P_HPOL[0]), .V_POL(P_VPOL[0]), .PIX_DIV(P_DIV[0]), .FETCH_LAT(P_LAT[0]),
        .R_DEPTH(2), .G_DEPTH(2), .B_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst_a), .pix_data(pix_a), .fetch_valid(fv_a), .fetch_x(fx_a),
        .fetch_y(fy_a), .h_sync_pulse(hs_a), .v_sync_pulse(vs_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a), .R(r_a), .G(g_a), .B(b_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(P_HA[1]), .H_FP(P_HF[1]), .H_SYNC(P_HS[1]), .H_BP(P_HB[1]),
        .V_ACTIVE(P_VA[1]), .V_FP(P_VF[1]), .V_SYNC(P_VS[1]), .V_BP(P_VB[1]),
        .H_POL(P_HPOL[1]), .V_POL(P_VPOL[1]), .PIX_DIV(P_DIV[1]), .FETCH_LAT(P_LAT[1]),
        .R_DEPTH(2), .G_DEPTH(2), .B_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_data(pix_b), .fetch_valid(fv_b), .fetch_x(fx_b),
        .fetch_y(fy_b), .h_sync_pulse(hs_b), .v_sync_pulse(vs_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b), .R(r_b), .G(g_b), .B(b_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(P_HA[2]), .H_FP(P_HF[2]), .H_SYNC(P_HS[2]), .H_BP(P_HB[2]),
        .V_ACTIVE(P_VA[2]), .V_FP(P_VF[2]), .V_SYNC(P_VS[2]), .V_BP(P_VB[2]),
        .H_POL(P_HPOL[2]), .V_POL(P_VPOL[2]), .PIX_DIV(P_DIV[2]), .FETCH_LAT(P_LAT[2]),
        .R_DEPTH(2), .G_DEPTH(2), .B_DEPTH(2)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pix_data(pix_c), .fetch_valid(fv_c), .fetch_x(fx_c),
        .fetch_y(fy_c), .h_sync_pulse(hs_c), .v_sync_pulse(vs_c), .de(de_c),
        .line_start(ls_c), .frame_start(fs_c), .R(r_c), .G(g_c), .B(b_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock of the model for configuration id, called mid-cycle with the DUT pins.
    task automatic applyStimulus(input int id, input bit rst_v, input bit fv, input int fx,
                                 input int fy, input bit de_o, input bit hs_o, input bit vs_o,
                                 input bit ls_o, input bit fs_o, input int rgb_o,
                                 output int pix);
        exp_t e;
        int   ht, vt, lat, dv;
        bit   exp_fv, act, in_hs, in_vs;
        string pfx;
        ht  = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
        vt  = P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
        lat = P_LAT[id];
        dv  = P_DIV[id];
        pfx = $sformatf("cfg%0d", id);
        act = (mh[id] < P_HA[id]) && (mv[id] < P_VA[id]);
        cyc[id]++;

        if (armed[id]) begin
            if (scb_q[id].size() == 0) begin
                checkOutput({pfx, " scoreboard empty"}, 0, 1);
            end else begin
                e = scb_q[id].pop_front();
                checkOutput({pfx, " de"}, int'(de_o), int'(e.de));
                checkOutput({pfx, " h_sync"}, int'(hs_o), int'(e.hs));
                checkOutput({pfx, " v_sync"}, int'(vs_o), int'(e.vs));
                checkOutput({pfx, " line_start"}, int'(ls_o), int'(e.ls));
                checkOutput({pfx, " frame_start"}, int'(fs_o), int'(e.fs));
                checkOutput({pfx, " rgb"}, rgb_o, e.rgb);
            end
            exp_fv = !rst_v && (mdiv[id] == 0) && act;
            checkOutput({pfx, " fetch_valid"}, int'(fv), int'(exp_fv));
            if (exp_fv) begin
                checkOutput({pfx, " fetch_x"}, fx, mh[id]);
                checkOutput({pfx, " fetch_y"}, fy, mv[id]);
            end
            if (!rst_v) begin
                if (ls_o) begin
                    if (have_ls[id]) checkOutput({pfx, " line period"}, cyc[id] - last_ls[id], ht * dv);
                    last_ls[id] = cyc[id];
                    have_ls[id] = 1'b1;
                end
                if (fs_o) begin
                    if (have_fs[id]) checkOutput({pfx, " frame period"}, cyc[id] - last_fs[id], ht * vt * dv);
                    last_fs[id] = cyc[id];
                    have_fs[id] = 1'b1;
                end
                if (hs_o == P_HPOL[id]) hs_run[id]++;
                else if (hs_run[id] > 0) begin
                    checkOutput({pfx, " h_sync width"}, hs_run[id], P_HS[id] * dv);
                    hs_run[id] = 0;
                end
                if (vs_o == P_VPOL[id]) vs_run[id]++;
                else if (vs_run[id] > 0) begin
                    checkOutput({pfx, " v_sync width"}, vs_run[id], P_VS[id] * ht * dv);
                    vs_run[id] = 0;
                end
            end
        end

        // Frame buffer answers exactly lat cycles after a request, noise otherwise.
        pix = fb_v[id][lat-1] ? fb_d[id][lat-1] : int'($urandom_range(0, 63));
        for (int k = 7; k > 0; k--) begin
            fb_v[id][k] = fb_v[id][k-1];
            fb_d[id][k] = fb_d[id][k-1];
        end
        fb_v[id][0] = fv;
        fb_d[id][0] = fx % 64;

        in_hs = (mh[id] >= P_HA[id] + P_HF[id]) && (mh[id] < P_HA[id] + P_HF[id] + P_HS[id]);
        in_vs = (mv[id] >= P_VA[id] + P_VF[id]) && (mv[id] < P_VA[id] + P_VF[id] + P_VS[id]);
        e.de  = act;
        e.rgb = act ? (mh[id] % 64) : 0;
        e.hs  = in_hs ? P_HPOL[id] : !P_HPOL[id];
        e.vs  = in_vs ? P_VPOL[id] : !P_VPOL[id];
        e.ls  = (mh[id] == 0) && (mdiv[id] == 0);
        e.fs  = e.ls && (mv[id] == 0);
        scb_q[id].push_back(e);

        if (rst_v) begin
            scb_q[id].delete();
            e.de  = 1'b0;
            e.rgb = 0;
            e.hs  = !P_HPOL[id];
            e.vs  = !P_VPOL[id];
            e.ls  = 1'b0;
            e.fs  = 1'b0;
            repeat (lat + 1) scb_q[id].push_back(e);
            armed[id]   = 1'b1;
            have_ls[id] = 1'b0;
            have_fs[id] = 1'b0;
            hs_run[id]  = 0;
            vs_run[id]  = 0;
            mh[id]      = 0;
            mv[id]      = 0;
            mdiv[id]    = 0;
        end else if (mdiv[id] == dv - 1) begin
            mdiv[id] = 0;
            if (mh[id] == ht - 1) begin
                mh[id] = 0;
                mv[id] = (mv[id] == vt - 1) ? 0 : mv[id] + 1;
            end else begin
                mh[id] = mh[id] + 1;
            end
        end else begin
            mdiv[id] = mdiv[id] + 1;
        end
    endtask

    always @(negedge clk) begin
        applyStimulus(0, rst_a, fv_a, int'(fx_a), int'(fy_a), de_a, hs_a, vs_a, ls_a, fs_a,
                      int'({r_a, g_a, b_a}), p_a);
        pix_a = 6'(p_a);
    end

    always @(negedge clk) begin
        applyStimulus(1, rst_b, fv_b, int'(fx_b), int'(fy_b), de_b, hs_b, vs_b, ls_b, fs_b,
                      int'({r_b, g_b, b_b}), p_b);
        pix_b = 6'(p_b);
    end

    always @(negedge clk) begin
        applyStimulus(2, rst_c, fv_c, int'(fx_c), int'(fy_c), de_c, hs_c, vs_c, ls_c, fs_c,
                      int'({r_c, g_c, b_c}), p_c);
        pix_c = 6'(p_c);
    end

    initial begin
        $display("[TB] starting vga_timing_gen bench");
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (21000) @(posedge clk);

        // Pulse reset on config 0 in the middle of a visible line.
        found = 1'b0;
        for (int n = 0; n < 12000 && !found; n++) begin
            @(posedge clk);
            #1;
            if (mh[0] == 150 && mv[0] == 5) found = 1'b1;
        end
        checkOutput("cfg0 mid-frame reset point reached", int'(found), 1);
        if (found) begin
            rst_a = 1'b1;
            @(posedge clk);
            #1;
            rst_a = 1'b0;
        end
        repeat (3000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
